// File: rtl/imager_ctrl.sv
// Capture sequencer: drives imager enable/mode/geometry, counts frames on fv edges, applies
// shadowed config only at frame boundaries; all outputs registered, fall seen 1 cycle after fv drops.
module imager_ctrl #(
  parameter int NUM_ROWS_WIDTH    = 12,
  parameter int NUM_COLS_WIDTH    = 12,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH     = 24
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_we,
  input  logic [2:0]                   cfg_mode,
  input  logic [NUM_ROWS_WIDTH-1:0]    cfg_active_rows,
  input  logic [NUM_ROWS_WIDTH-1:0]    cfg_virtual_rows,
  input  logic [NUM_COLS_WIDTH-1:0]    cfg_active_cols,
  input  logic [NUM_COLS_WIDTH-1:0]    cfg_virtual_cols,
  input  logic                         start,
  input  logic                         stop,
  input  logic [FRAME_COUNT_WIDTH-1:0] num_frames,
  input  logic [TIMEOUT_WIDTH-1:0]     timeout_cycles,
  input  logic                         fv,
  output logic                         img_enable,
  output logic [2:0]                   img_mode,
  output logic [NUM_ROWS_WIDTH-1:0]    img_active_rows,
  output logic [NUM_ROWS_WIDTH-1:0]    img_virtual_rows,
  output logic [NUM_COLS_WIDTH-1:0]    img_active_cols,
  output logic [NUM_COLS_WIDTH-1:0]    img_virtual_cols,
  output logic                         busy,
  output logic                         frame_done,
  output logic [FRAME_COUNT_WIDTH-1:0] frames_captured,
  output logic                         capture_done,
  output logic                         timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [FRAME_COUNT_WIDTH-1:0] FRAME_ONE = FRAME_COUNT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0]     WD_ONE    = TIMEOUT_WIDTH'(1);

  state_t                         state;
  logic                           fv_q;
  logic                           cfg_pending;
  logic                           stop_pending;
  logic [2:0]                     shd_mode;
  logic [NUM_ROWS_WIDTH-1:0]      shd_active_rows;
  logic [NUM_ROWS_WIDTH-1:0]      shd_virtual_rows;
  logic [NUM_COLS_WIDTH-1:0]      shd_active_cols;
  logic [NUM_COLS_WIDTH-1:0]      shd_virtual_cols;
  logic [FRAME_COUNT_WIDTH-1:0]   frames_target;
  logic [FRAME_COUNT_WIDTH-1:0]   frames_next;
  logic [TIMEOUT_WIDTH-1:0]       wd_cnt;
  logic [TIMEOUT_WIDTH-1:0]       wd_next;
  logic                           fv_rise;
  logic                           fv_fall;
  logic                           wd_on;
  logic                           wd_expire;
  logic                           last_frame;
  logic                           end_capture;
  logic                           apply_cfg;

  assign fv_rise     = fv & ~fv_q;
  assign fv_fall     = ~fv & fv_q;
  assign wd_on       = (timeout_cycles != '0);
  assign wd_next     = wd_cnt + WD_ONE;
  assign wd_expire   = wd_on && (wd_next == timeout_cycles);
  assign frames_next = (&frames_captured) ? frames_captured : frames_captured + FRAME_ONE;
  assign last_frame  = (frames_target != '0) && (frames_next == frames_target);
  assign end_capture = last_frame || stop_pending || stop;
  assign apply_cfg   = ((state == IDLE) && cfg_pending) || ((state == CAPTURE) && fv_fall);

  // A write coinciding with an apply lands in shadow and keeps pending set for the next boundary.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shd_mode         <= '0;
      shd_active_rows  <= '0;
      shd_virtual_rows <= '0;
      shd_active_cols  <= '0;
      shd_virtual_cols <= '0;
      cfg_pending      <= 1'b0;
      img_mode         <= '0;
      img_active_rows  <= '0;
      img_virtual_rows <= '0;
      img_active_cols  <= '0;
      img_virtual_cols <= '0;
    end else begin
      if (apply_cfg) begin
        img_mode         <= shd_mode;
        img_active_rows  <= shd_active_rows;
        img_virtual_rows <= shd_virtual_rows;
        img_active_cols  <= shd_active_cols;
        img_virtual_cols <= shd_virtual_cols;
      end
      if (cfg_we) begin
        shd_mode         <= cfg_mode;
        shd_active_rows  <= cfg_active_rows;
        shd_virtual_rows <= cfg_virtual_rows;
        shd_active_cols  <= cfg_active_cols;
        shd_virtual_cols <= cfg_virtual_cols;
        cfg_pending      <= 1'b1;
      end else if (apply_cfg) begin
        cfg_pending      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      fv_q            <= 1'b0;
      stop_pending    <= 1'b0;
      frames_target   <= '0;
      frames_captured <= '0;
      wd_cnt          <= '0;
      img_enable      <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      capture_done    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      fv_q         <= fv;
      frame_done   <= 1'b0;
      capture_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= ARM;
            img_enable      <= 1'b1;
            busy            <= 1'b1;
            frames_target   <= num_frames;
            frames_captured <= '0;
            wd_cnt          <= '0;
            timeout_err     <= 1'b0;
            stop_pending    <= 1'b0;
          end
        end
        ARM: begin
          if (stop) begin
            state        <= IDLE;
            img_enable   <= 1'b0;
            busy         <= 1'b0;
            capture_done <= 1'b1;
          end else if (fv_rise) begin
            state  <= CAPTURE;
            wd_cnt <= '0;
          end else if (wd_expire) begin
            state       <= IDLE;
            img_enable  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else if (wd_on) begin
            wd_cnt <= wd_next;
          end
        end
        CAPTURE: begin
          // A fall outranks a coincident watchdog expiry.
          if (fv_fall) begin
            frame_done      <= 1'b1;
            frames_captured <= frames_next;
            wd_cnt          <= '0;
            if (end_capture) begin
              state        <= IDLE;
              img_enable   <= 1'b0;
              busy         <= 1'b0;
              capture_done <= 1'b1;
              stop_pending <= 1'b0;
            end
          end else if (wd_expire && !fv_rise) begin
            state        <= IDLE;
            img_enable   <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b1;
            stop_pending <= 1'b0;
          end else begin
            if (stop) begin
              stop_pending <= 1'b1;
            end
            if (fv_rise) begin
              wd_cnt <= '0;
            end else if (wd_on) begin
              wd_cnt <= wd_next;
            end
          end
        end
        default: begin
          state      <= IDLE;
          img_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imager_ctrl.sv
// Bench for imager_ctrl: behavioural imager, table-driven captures, corner sequences, random runs.
module tb_imager_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [2:0]  cfg_mode;
  logic [11:0] cfg_active_rows, cfg_virtual_rows, cfg_active_cols, cfg_virtual_cols;
  logic        start, stop;
  logic [15:0] num_frames;
  logic [23:0] timeout_cycles;
  logic        fv;
  logic        img_enable;
  logic [2:0]  img_mode;
  logic [11:0] img_active_rows, img_virtual_rows, img_active_cols, img_virtual_cols;
  logic        busy, frame_done, capture_done, timeout_err;
  logic [15:0] frames_captured;

  always #5 clk = ~clk;

  imager_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cfg_active_rows(cfg_active_rows), .cfg_virtual_rows(cfg_virtual_rows),
    .cfg_active_cols(cfg_active_cols), .cfg_virtual_cols(cfg_virtual_cols),
    .start(start), .stop(stop), .num_frames(num_frames), .timeout_cycles(timeout_cycles),
    .fv(fv), .img_enable(img_enable), .img_mode(img_mode),
    .img_active_rows(img_active_rows), .img_virtual_rows(img_virtual_rows),
    .img_active_cols(img_active_cols), .img_virtual_cols(img_virtual_cols),
    .busy(busy), .frame_done(frame_done), .frames_captured(frames_captured),
    .capture_done(capture_done), .timeout_err(timeout_err)
  );

  // Imager: fv high for active_rows*line cycles, low for virtual_rows*line, geometry taken at frame start.
  logic fv_img = 1'b0;
  logic fv_block = 1'b0;
  int   im_cnt = 0, im_active = 0, im_period = 0, a_now, p_now;
  assign a_now = int'(img_active_rows) * (int'(img_active_cols) + int'(img_virtual_cols));
  assign p_now = (int'(img_active_rows) + int'(img_virtual_rows)) *
                 (int'(img_active_cols) + int'(img_virtual_cols));
  assign fv = fv_img & ~fv_block;

  always @(posedge clk) begin
    if (!img_enable) begin
      im_cnt <= 0;
      fv_img <= 1'b0;
    end else if (im_cnt == 0) begin
      im_active <= a_now;
      im_period <= p_now;
      fv_img    <= (a_now > 0);
      im_cnt    <= (p_now > 1) ? 1 : 0;
    end else begin
      fv_img <= (im_cnt < im_active);
      im_cnt <= (im_cnt == im_period - 1) ? 0 : im_cnt + 1;
    end
  end

  int cyc = 0;
  int fd_q[$];
  int cd_q[$];
  int t_start = 0;
  int checks = 0;
  int errors = 0;
  int exp_mode = 0, exp_ar = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if (capture_done === 1'b1) cd_q.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic configure(input logic [2:0] m, input int ar, input int vr, input int ac,
                           input int vc);
    @(negedge clk);
    cfg_mode         = m;
    cfg_active_rows  = 12'(ar);
    cfg_virtual_rows = 12'(vr);
    cfg_active_cols  = 12'(ac);
    cfg_virtual_cols = 12'(vc);
    cfg_we           = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_hold_mode", img_mode, exp_mode);
    check("cfg_hold_rows", img_active_rows, exp_ar);
    @(negedge clk);
    check("cfg_apply_mode", img_mode, m);
    check("cfg_apply_arows", img_active_rows, ar);
    check("cfg_apply_vrows", img_virtual_rows, vr);
    check("cfg_apply_acols", img_active_cols, ac);
    check("cfg_apply_vcols", img_virtual_cols, vc);
    exp_mode = int'(m);
    exp_ar   = ar;
  endtask

  task automatic do_start(input int nf, input logic with_stop);
    @(negedge clk);
    num_frames = 16'(nf);
    start      = 1'b1;
    stop       = with_stop;
    fd_q.delete();
    cd_q.delete();
    t_start    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run_capture(input logic [2:0] m, input int ar, input int vr, input int ac,
                             input int vc, input int nf, input int exp_frames, input int exp_done);
    int p;
    p = (ar + vr) * (ac + vc);
    configure(m, ar, vr, ac, vc);
    do_start(nf, 1'b0);
    check("start_busy", busy, 1);
    check("start_enable", img_enable, 1);
    wait_idle(3000);
    @(negedge clk);
    check("frames_captured", frames_captured, exp_frames);
    check("frame_done_count", fd_q.size(), exp_frames);
    check("capture_done_count", cd_q.size(), 1);
    if (cd_q.size() == 1) check("capture_done_time", cd_q[0] - t_start, exp_done);
    if (fd_q.size() == exp_frames && cd_q.size() == 1) begin
      check("last_frame_with_done", fd_q[exp_frames-1], cd_q[0]);
      for (int k = 1; k < fd_q.size(); k++) check("frame_spacing", fd_q[k] - fd_q[k-1], p);
    end
    check("end_enable", img_enable, 0);
    check("end_timeout_err", timeout_err, 0);
  endtask

  typedef struct {
    logic [2:0] mode;
    int ar; int vr; int ac; int vc; int nf;
    int exp_frames; int exp_done;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, ar, vr, ac, vc, nf, a, p;
    logic [2:0] m;

    vecs[0] = '{3'd1, 4, 2, 8, 4, 1, 1, 50};
    vecs[1] = '{3'd2, 4, 2, 8, 4, 3, 3, 194};
    vecs[2] = '{3'd5, 2, 1, 3, 2, 2, 2, 27};
    vecs[3] = '{3'd7, 1, 1, 1, 1, 4, 4, 16};

    reset_n = 1'b0; cfg_we = 1'b0; cfg_mode = '0;
    cfg_active_rows = '0; cfg_virtual_rows = '0; cfg_active_cols = '0; cfg_virtual_cols = '0;
    start = 1'b0; stop = 1'b0; num_frames = '0; timeout_cycles = '0;
    repeat (3) @(negedge clk);
    check("rst_enable", img_enable, 0);
    check("rst_mode", img_mode, 0);
    check("rst_arows", img_active_rows, 0);
    check("rst_vrows", img_virtual_rows, 0);
    check("rst_acols", img_active_cols, 0);
    check("rst_vcols", img_virtual_cols, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_capture_done", capture_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_frames", frames_captured, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_capture(vecs[i].mode, vecs[i].ar, vecs[i].vr, vecs[i].ac, vecs[i].vc, vecs[i].nf,
                  vecs[i].exp_frames, vecs[i].exp_done);

    // Continuous capture stopped mid-frame 2; a start while busy must be ignored.
    configure(3'd1, 4, 2, 8, 4);
    do_start(0, 1'b0);
    n = 0;
    while (fd_q.size() < 1 && n < 500) begin @(negedge clk); n++; end
    while (cyc < t_start + 90) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    num_frames = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(500);
    @(negedge clk);
    check("stop_frames", frames_captured, 2);
    check("stop_fd_count", fd_q.size(), 2);
    check("stop_cd_count", cd_q.size(), 1);
    if (cd_q.size() == 1) check("stop_cd_time", cd_q[0] - t_start, 122);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("idle_stop_busy", busy, 0);
    @(negedge clk);
    check("idle_stop_no_done", cd_q.size(), 1);

    // Mid-capture reconfiguration applies at frame 1's fall; start+stop together starts.
    do_start(2, 1'b1);
    check("start_wins_busy", busy, 1);
    while (cyc < t_start + 20) @(negedge clk);
    cfg_mode = 3'd3; cfg_active_rows = 12'd6; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    while (cyc < t_start + 49) @(negedge clk);
    check("mid_cfg_mode_hold", img_mode, 1);
    check("mid_cfg_rows_hold", img_active_rows, 4);
    check("mid_cfg_no_fd_yet", frame_done, 0);
    @(negedge clk);
    check("mid_cfg_fd", frame_done, 1);
    check("mid_cfg_frames1", frames_captured, 1);
    check("mid_cfg_mode_new", img_mode, 3);
    check("mid_cfg_rows_new", img_active_rows, 6);
    check("mid_cfg_busy", busy, 1);
    exp_mode = 3; exp_ar = 6;
    wait_idle(500);
    @(negedge clk);
    check("mid_cfg_frames", frames_captured, 2);
    check("mid_cfg_fd_count", fd_q.size(), 2);
    if (fd_q.size() == 2) check("mid_cfg_frame2_span", fd_q[1] - fd_q[0], 96);
    check("mid_cfg_cd_count", cd_q.size(), 1);
    if (cd_q.size() == 1) check("mid_cfg_cd_time", cd_q[0] - t_start, 146);

    // Watchdog: fv stuck low, limit 10.
    fv_block = 1'b1;
    timeout_cycles = 24'd10;
    do_start(1, 1'b0);
    while (cyc < t_start + 9) @(negedge clk);
    check("wd_busy_before", busy, 1);
    check("wd_err_before", timeout_err, 0);
    @(negedge clk);
    check("wd_busy_after", busy, 0);
    check("wd_err_after", timeout_err, 1);
    check("wd_enable_after", img_enable, 0);
    repeat (3) @(negedge clk);
    check("wd_no_capture_done", cd_q.size(), 0);
    check("wd_err_sticky", timeout_err, 1);
    fv_block = 1'b0;
    timeout_cycles = 24'd0;
    do_start(1, 1'b0);
    check("wd_err_cleared", timeout_err, 0);
    check("wd_restart_busy", busy, 1);
    wait_idle(500);
    @(negedge clk);
    check("wd_restart_frames", frames_captured, 1);
    if (cd_q.size() == 1) check("wd_restart_cd_time", cd_q[0] - t_start, 74);
    else check("wd_restart_cd_count", cd_q.size(), 1);

    // Reset pulse in mid-capture.
    do_start(0, 1'b0);
    while (cyc < t_start + 30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_enable", img_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mode", img_mode, 0);
    check("mid_rst_arows", img_active_rows, 0);
    check("mid_rst_frames", frames_captured, 0);
    check("mid_rst_fd", frame_done, 0);
    check("mid_rst_cd", capture_done, 0);
    check("mid_rst_err", timeout_err, 0);
    exp_mode = 0; exp_ar = 0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_pulse", cd_q.size(), 0);
    run_capture(3'd2, 3, 1, 4, 2, 1, 1, 20);

    // Random captures against the frame-timing model.
    for (int it = 0; it < 6; it++) begin
      m  = 3'($urandom_range(0, 7));
      ar = $urandom_range(1, 4);
      vr = $urandom_range(1, 3);
      ac = $urandom_range(1, 6);
      vc = $urandom_range(1, 4);
      nf = $urandom_range(1, 3);
      a  = ar * (ac + vc);
      p  = (ar + vr) * (ac + vc);
      timeout_cycles = (it % 2 == 1) ? 24'd200 : 24'd0;
      run_capture(m, ar, vr, ac, vc, nf, nf, a + 2 + (nf - 1) * p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
